aha_axi_lite_to_apb: RTL and testbench

- AXI-Lite slave to APB (APB4 signalling) master bridge.
- Sits directly downstream of the AXI4-to-AXI-Lite converter and consumes its LITE_* master interface.
- Drives a single APB completer, such as a peripheral register bank in the Garnet integration.
- Serialises transfers: exactly one AXI-Lite read or write is outstanding at a time, arbitrated fairly.

---
 rtl/aha_apb_pkg.sv | 16 +
 rtl/aha_apb_timeout_ctr.sv | 29 ++
 rtl/aha_axi_lite_to_apb.sv | 178 +++++++++++++++++
 tb/tb_aha_axi_lite_to_apb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aha_apb_pkg.sv
// Shared types and constants for the AXI-Lite to APB bridge.
// Used by aha_axi_lite_to_apb and the optional AHA_APB_TIMEOUT_EN counter.
package aha_apb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StWresp,
        StRresp
    } apb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/aha_apb_timeout_ctr.sv
// ACCESS-phase watchdog for aha_axi_lite_to_apb, built only with AHA_APB_TIMEOUT_EN.
// o_expired fires in the ACCESS cycle that would be the LIMIT-th one without PREADY.
module aha_apb_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam logic [15:0] LastCount = 16'(LIMIT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_expired = i_count && (r_cnt == LastCount);

endmodule

// File: rtl/aha_axi_lite_to_apb.sv
// AXI-Lite slave to APB4 master bridge; one transfer in flight, fair write/read alternation.
// Define AHA_APB_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES and end stuck transfers with SLVERR.
module aha_axi_lite_to_apb
    import aha_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] LITE_AWADDR,
    input  logic                  LITE_AWVALID,
    output logic                  LITE_AWREADY,
    input  logic [31:0]           LITE_WDATA,
    input  logic [3:0]            LITE_WSTRB,
    input  logic                  LITE_WVALID,
    output logic                  LITE_WREADY,
    output logic [1:0]            LITE_BRESP,
    output logic                  LITE_BVALID,
    input  logic                  LITE_BREADY,
    input  logic [ADDR_WIDTH-1:0] LITE_ARADDR,
    input  logic                  LITE_ARVALID,
    output logic                  LITE_ARREADY,
    output logic [31:0]           LITE_RDATA,
    output logic [1:0]            LITE_RRESP,
    output logic                  LITE_RVALID,
    input  logic                  LITE_RREADY,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [3:0]            PSTRB,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    apb_state_e            r_state;
    logic                  r_last_wr;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [31:0]           r_pwdata;
    logic [3:0]            r_pstrb;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [31:0]           r_rdata;

    logic       w_idle;
    logic       w_wr_cand;
    logic       w_rd_cand;
    logic       w_grant_wr;
    logic       w_grant_rd;
    logic       w_done;
    logic       w_timeout;
    logic       w_finish;
    logic [1:0] w_resp;

    assign w_idle    = (r_state == StIdle);
    assign w_wr_cand = LITE_AWVALID & LITE_WVALID;
    assign w_rd_cand = LITE_ARVALID;

    // On a tie the channel not granted last time wins.
    assign w_grant_wr = w_idle & w_wr_cand & (~w_rd_cand | ~r_last_wr);
    assign w_grant_rd = w_idle & w_rd_cand & (~w_wr_cand | r_last_wr);

    assign w_done   = (r_state == StAccess) & PREADY;
    assign w_finish = w_done | w_timeout;
    assign w_resp   = (w_done && !PSLVERR) ? RESP_OKAY : RESP_SLVERR;

`ifdef AHA_APB_TIMEOUT_EN
    aha_apb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .i_clk     (ACLK),
        .i_rst_n   (ARESETn),
        .i_clear   (r_state == StSetup),
        .i_count   ((r_state == StAccess) && !PREADY),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= StIdle;
            r_last_wr <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_wr || w_grant_rd) begin
                        r_state   <= StSetup;
                        r_last_wr <= w_grant_wr;
                        r_paddr   <= w_grant_wr ? LITE_AWADDR : LITE_ARADDR;
                        r_pwrite  <= w_grant_wr;
                        r_pstrb   <= w_grant_wr ? LITE_WSTRB : 4'h0;
                        r_psel    <= 1'b1;
                        if (w_grant_wr) begin
                            r_pwdata <= LITE_WDATA;
                        end
                    end
                end
                StSetup: begin
                    r_penable <= 1'b1;
                    r_state   <= StAccess;
                end
                StAccess: begin
                    if (w_finish) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (r_pwrite) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_resp;
                            r_state  <= StWresp;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= w_resp;
                            r_rdata  <= w_done ? PRDATA : 32'h0;
                            r_state  <= StRresp;
                        end
                    end
                end
                StWresp: begin
                    if (LITE_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= RESP_OKAY;
                        r_state  <= StIdle;
                    end
                end
                StRresp: begin
                    if (LITE_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rresp  <= RESP_OKAY;
                        r_rdata  <= '0;
                        r_state  <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign LITE_AWREADY = w_grant_wr;
    assign LITE_WREADY  = w_grant_wr;
    assign LITE_ARREADY = w_grant_rd;
    assign LITE_BVALID  = r_bvalid;
    assign LITE_BRESP   = r_bresp;
    assign LITE_RVALID  = r_rvalid;
    assign LITE_RRESP   = r_rresp;
    assign LITE_RDATA   = r_rdata;
    assign PADDR        = r_paddr;
    assign PSEL         = r_psel;
    assign PENABLE      = r_penable;
    assign PWRITE       = r_pwrite;
    assign PWDATA       = r_pwdata;
    assign PSTRB        = r_pstrb;

endmodule

// File: tb/tb_aha_axi_lite_to_apb.sv
// Self-checking bench for aha_axi_lite_to_apb: vector table plus hand-written corner sequences.
// The timeout sequence is compiled only when AHA_APB_TIMEOUT_EN is defined.
module tb_aha_axi_lite_to_apb;

    localparam int unsigned AW         = 32;
    localparam int unsigned TB_TIMEOUT = 8;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [AW-1:0] LITE_AWADDR = '0;
    logic          LITE_AWVALID = 1'b0;
    logic          LITE_AWREADY;
    logic [31:0]   LITE_WDATA = '0;
    logic [3:0]    LITE_WSTRB = '0;
    logic          LITE_WVALID = 1'b0;
    logic          LITE_WREADY;
    logic [1:0]    LITE_BRESP;
    logic          LITE_BVALID;
    logic          LITE_BREADY = 1'b0;
    logic [AW-1:0] LITE_ARADDR = '0;
    logic          LITE_ARVALID = 1'b0;
    logic          LITE_ARREADY;
    logic [31:0]   LITE_RDATA;
    logic [1:0]    LITE_RRESP;
    logic          LITE_RVALID;
    logic          LITE_RREADY = 1'b0;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic          PREADY = 1'b0;
    logic [31:0]   PRDATA = '0;
    logic          PSLVERR = 1'b0;

    always #5 ACLK = ~ACLK;

    aha_axi_lite_to_apb #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .LITE_AWADDR  (LITE_AWADDR),
        .LITE_AWVALID (LITE_AWVALID),
        .LITE_AWREADY (LITE_AWREADY),
        .LITE_WDATA   (LITE_WDATA),
        .LITE_WSTRB   (LITE_WSTRB),
        .LITE_WVALID  (LITE_WVALID),
        .LITE_WREADY  (LITE_WREADY),
        .LITE_BRESP   (LITE_BRESP),
        .LITE_BVALID  (LITE_BVALID),
        .LITE_BREADY  (LITE_BREADY),
        .LITE_ARADDR  (LITE_ARADDR),
        .LITE_ARVALID (LITE_ARVALID),
        .LITE_ARREADY (LITE_ARREADY),
        .LITE_RDATA   (LITE_RDATA),
        .LITE_RRESP   (LITE_RRESP),
        .LITE_RVALID  (LITE_RVALID),
        .LITE_RREADY  (LITE_RREADY),
        .PADDR        (PADDR),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PSTRB        (PSTRB),
        .PREADY       (PREADY),
        .PRDATA       (PRDATA),
        .PSLVERR      (PSLVERR)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] prdata;
        logic        slverr;
        int          delay;
        int          hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {LITE_AWREADY, LITE_WREADY, LITE_BRESP, LITE_BVALID, LITE_ARREADY, LITE_RDATA,
                LITE_RRESP, LITE_RVALID, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB};
    endfunction

    task automatic idle_inputs();
        LITE_AWVALID = 1'b0;
        LITE_WVALID  = 1'b0;
        LITE_ARVALID = 1'b0;
        LITE_BREADY  = 1'b0;
        LITE_RREADY  = 1'b0;
        PREADY       = 1'b0;
        PSLVERR      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
    endtask

    // Presents a request and waits (bounded) for its handshake; returns just after the accept edge.
    task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output bit ok);
        ok = 1'b0;
        @(posedge ACLK);
        #1;
        if (wr) begin
            LITE_AWADDR  = addr;
            LITE_WDATA   = wdata;
            LITE_WSTRB   = wstrb;
            LITE_AWVALID = 1'b1;
            LITE_WVALID  = 1'b1;
        end else begin
            LITE_ARADDR  = addr;
            LITE_ARVALID = 1'b1;
        end
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge ACLK);
            ok = wr ? (LITE_AWREADY && LITE_WREADY) : LITE_ARREADY;
        end
        @(posedge ACLK);
        #1;
        LITE_AWVALID = 1'b0;
        LITE_WVALID  = 1'b0;
        LITE_ARVALID = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int lat;
        int acc_cycles;
        accept(v.wr, v.addr, v.wdata, v.wstrb, ok);
        check($sformatf("v%0d_accept", idx), ok, 1);
        if (!ok) return;
        lat        = 0;
        acc_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge ACLK);
            if (c == 1) check($sformatf("v%0d_setup", idx), {PSEL, PENABLE}, 2'b10);
            if (LITE_BVALID || LITE_RVALID) begin
                lat = c;
                break;
            end
            if (PSEL && PENABLE) begin
                acc_cycles++;
                check($sformatf("v%0d_paddr", idx), PADDR, v.addr);
                check($sformatf("v%0d_pwrite", idx), PWRITE, v.wr);
                check($sformatf("v%0d_pstrb", idx), PSTRB, v.wr ? v.wstrb : 4'h0);
                if (v.wr) check($sformatf("v%0d_pwdata", idx), PWDATA, v.wdata);
            end
            PREADY  = PSEL && PENABLE && (acc_cycles > v.delay);
            PRDATA  = v.prdata;
            PSLVERR = v.slverr;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_apb_idle", idx), {PSEL, PENABLE}, 2'b00);
        check($sformatf("v%0d_valids", idx), {LITE_BVALID, LITE_RVALID}, v.wr ? 2'b10 : 2'b01);
        check($sformatf("v%0d_resp", idx), v.wr ? LITE_BRESP : LITE_RRESP, v.exp_resp);
        check($sformatf("v%0d_rdata", idx), LITE_RDATA, v.exp_rdata);
        // Competing requests during response back-pressure must not be accepted.
        if (v.hold > 0) begin
            LITE_AWADDR  = 32'h0000_0F00;
            LITE_ARADDR  = 32'h0000_0F04;
            LITE_AWVALID = 1'b1;
            LITE_WVALID  = 1'b1;
            LITE_ARVALID = 1'b1;
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge ACLK);
            check($sformatf("v%0d_hold_ready", idx),
                  {LITE_AWREADY, LITE_WREADY, LITE_ARREADY, PSEL}, 4'b0000);
            check($sformatf("v%0d_hold_resp", idx),
                  {LITE_BVALID, LITE_RVALID, LITE_BRESP, LITE_RRESP, LITE_RDATA},
                  {v.wr, !v.wr, v.wr ? v.exp_resp : 2'b00, v.wr ? 2'b00 : v.exp_resp,
                   v.exp_rdata});
        end
        LITE_AWVALID = 1'b0;
        LITE_WVALID  = 1'b0;
        LITE_ARVALID = 1'b0;
        LITE_BREADY  = 1'b1;
        LITE_RREADY  = 1'b1;
        @(negedge ACLK);
        check($sformatf("v%0d_retire", idx), {LITE_BVALID, LITE_RVALID, PSEL, LITE_RDATA},
              35'h0);
        LITE_BREADY = 1'b0;
        LITE_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit found;
        int acc;
        bit exp_order[4];

        //        wr    addr          wdata         strb  prdata        err   dly hold resp   rdata         lat
        vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'hFFFF_FFFF, 1'b0, 0, 0, 2'b00, 32'h0,         3};
        vecs[1] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 5, 0, 2'b00, 32'h1234_5678, 8};
        vecs[2] = '{1'b0, 32'h0000_0048, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b1, 0, 3, 2'b10, 32'hCAFE_F00D, 3};
        vecs[3] = '{1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h5, 32'h8765_4321, 1'b1, 2, 2, 2'b10, 32'h0,         5};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0000_0001, 1'b0, 1, 1, 2'b00, 32'h0000_0001, 4};

        do_reset();
        @(negedge ACLK);
        check("reset_outputs", all_outs(), 128'h0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Simultaneous write and read requests from reset alternate W, R, W, R.
        do_reset();
        exp_order    = '{1'b1, 1'b0, 1'b1, 1'b0};
        LITE_AWADDR  = 32'h0000_0200;
        LITE_WDATA   = 32'h1111_2222;
        LITE_WSTRB   = 4'hF;
        LITE_ARADDR  = 32'h0000_0300;
        LITE_AWVALID = 1'b1;
        LITE_WVALID  = 1'b1;
        LITE_ARVALID = 1'b1;
        PREADY       = 1'b1;
        LITE_BREADY  = 1'b1;
        LITE_RREADY  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            for (int n = 0; n < 10 && !found; n++) begin
                @(negedge ACLK);
                if (LITE_AWREADY || LITE_ARREADY) begin
                    found = 1'b1;
                    check($sformatf("arb_grant%0d", g), {LITE_AWREADY, LITE_WREADY, LITE_ARREADY},
                          exp_order[g] ? 3'b110 : 3'b001);
                end
            end
            check($sformatf("arb_found%0d", g), found, 1);
        end
        @(posedge ACLK);
        #1;
        LITE_AWVALID = 1'b0;
        LITE_WVALID  = 1'b0;
        LITE_ARVALID = 1'b0;
        repeat (6) @(posedge ACLK);
        #1 idle_inputs();

        // AW alone is never accepted; adding W makes both readies pulse together.
        LITE_AWADDR  = 32'h0000_0080;
        LITE_AWVALID = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge ACLK);
            check("aw_only_stall", {LITE_AWREADY, LITE_WREADY, LITE_ARREADY, PSEL}, 4'b0000);
        end
        LITE_WDATA  = 32'h55AA_55AA;
        LITE_WSTRB  = 4'h3;
        LITE_WVALID = 1'b1;
        #1;
        check("aw_w_pair_ready", {LITE_AWREADY, LITE_WREADY}, 2'b11);
        @(posedge ACLK);
        #1;
        LITE_AWVALID = 1'b0;
        LITE_WVALID  = 1'b0;
        PREADY       = 1'b1;
        LITE_BREADY  = 1'b1;
        found        = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge ACLK);
            if (PSEL && PENABLE) check("aw_w_pstrb", {PSTRB, PWDATA}, {4'h3, 32'h55AA_55AA});
            if (LITE_BVALID) begin
                found = 1'b1;
                check("aw_w_bresp", LITE_BRESP, 2'b00);
            end
        end
        check("aw_w_bvalid_seen", found, 1);
        @(posedge ACLK);
        #1 idle_inputs();

`ifdef AHA_APB_TIMEOUT_EN
        // PREADY never arrives: SLVERR with zero data after TB_TIMEOUT ACCESS cycles.
        PRDATA = 32'hA5A5_A5A5;
        accept(1'b0, 32'h0000_0600, 32'h0, 4'h0, ok);
        check("to_accept", ok, 1);
        acc   = 0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge ACLK);
            if (LITE_RVALID) found = 1'b1;
            else if (PSEL && PENABLE) acc++;
        end
        check("to_rvalid_seen", found, 1);
        check("to_access_cycles", acc, TB_TIMEOUT);
        check("to_resp", {LITE_RRESP, LITE_RDATA, PSEL, PENABLE}, {2'b10, 32'h0, 2'b00});
        PREADY = 1'b1;
        @(negedge ACLK);
        check("to_late_pready", {LITE_RVALID, LITE_RRESP, LITE_RDATA}, {1'b1, 2'b10, 32'h0});
        PREADY      = 1'b0;
        LITE_RREADY = 1'b1;
        @(negedge ACLK);
        check("to_retire", {LITE_RVALID, PSEL}, 2'b00);
        LITE_RREADY = 1'b0;
`endif

        // Asynchronous reset in the middle of ACCESS clears every output at once.
        accept(1'b0, 32'h0000_0500, 32'h0, 4'h0, ok);
        check("rst_accept", ok, 1);
        repeat (3) @(negedge ACLK);
        check("rst_in_access", {PSEL, PENABLE, PADDR}, {2'b11, 32'h0000_0500});
        #2 ARESETn = 1'b0;
        #1;
        check("rst_async_outputs", all_outs(), 128'h0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_release_idle", all_outs(), 128'h0);
        run_vec(vecs[0], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
